// File: rtl/fifo_rd_drain_pkg.sv
// Shared definitions for the FIFO read-side drain: FSM encoding, default widths
// and the skid-buffer credit check used to gate pops.
package fifo_rd_drain_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 16;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // Room for one more word once the in-flight read lands: occ + rdq - deq < 2.
  function automatic logic has_credit(input logic [1:0] occ,
                                      input logic       rdq,
                                      input logic       deq);
    logic [2:0] pend;
    pend = {1'b0, occ} + {2'b0, rdq};
    return pend < (3'd2 + {2'b0, deq});
  endfunction

endpackage

// File: rtl/fifo_rd_drain_skid.sv
// Two-entry skid buffer: words written at the tail, head presented combinationally.
// Enqueue and dequeue in one cycle keep occupancy unchanged; clr empties it.
module rd_skid_buf
  import fifo_rd_drain_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  enq,
  input  logic [data_width-1:0] enq_data,
  input  logic                  deq,
  output logic [1:0]            occ,
  output logic [data_width-1:0] head_data
);

  logic [data_width-1:0] mem0_q, mem0_d;
  logic [data_width-1:0] mem1_q, mem1_d;
  logic                  hd_q, hd_d;
  logic [1:0]            occ_q, occ_d;
  logic                  wr_ptr;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    hd_d   = hd_q;
    occ_d  = occ_q;
    // Tail slot is head + occ modulo 2; occ = 2 never coincides with a write.
    wr_ptr = hd_q ^ occ_q[0];
    if (clr) begin
      occ_d = 2'd0;
    end else begin
      if (enq) begin
        if (wr_ptr) mem1_d = enq_data;
        else        mem0_d = enq_data;
      end
      if (deq) hd_d = ~hd_q;
      case ({enq, deq})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      hd_q   <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      hd_q   <= hd_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = hd_q ? mem1_q : mem0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Pops the FIFO read port into a 2-entry skid buffer and streams words downstream
// (2-cycle pop-to-valid latency, 1 word/cycle); flush drains and discards the FIFO.
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int cnt_width  = CNT_WIDTH_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rst_in_rd,
  input  logic                  empty_in,
  input  logic [data_width-1:0] data_in,
  output logic                  rd_en_out,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic [cnt_width-1:0]  deliv_cnt
);

  logic [1:0]            state_q, state_d;
  logic                  rdq_q, rdq_d;
  logic [cnt_width-1:0]  cnt_q, cnt_d;

  logic [1:0]            occ;
  logic [data_width-1:0] head_data;
  logic                  in_run;
  logic                  deq;
  logic                  enq;
  logic                  clr;
  logic                  rd_req;

  assign in_run = (state_q == ST_RUN);
  assign deq    = m_valid && m_ready;
  // Words landing outside RUN belong to the flush and are dropped.
  assign enq    = rdq_q && in_run;
  assign clr    = !in_run || flush;

  always_comb begin
    state_d = state_q;
    rd_req  = 1'b0;
    case (state_q)
      ST_RUN: begin
        rd_req = !empty_in && has_credit(occ, rdq_q, deq);
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        rd_req = !empty_in;
        if (!flush) state_d = ST_SETTLE;
      end
      // No pop issued here, so the word landing this cycle is the last in flight.
      ST_SETTLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rd_en_out = rd_req && !rst_in_rd;
    rdq_d     = rd_en_out;
    cnt_d     = cnt_q + {{(cnt_width-1){1'b0}}, deq};
  end

  always_ff @(posedge rd_clk or posedge rst_in_rd) begin
    if (rst_in_rd) begin
      state_q <= ST_RUN;
      rdq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdq_q   <= rdq_d;
      cnt_q   <= cnt_d;
    end
  end

  rd_skid_buf #(
    .data_width(data_width)
  ) u_skid (
    .clk      (rd_clk),
    .rst      (rst_in_rd),
    .clr      (clr),
    .enq      (enq),
    .enq_data (data_in),
    .deq      (deq),
    .occ      (occ),
    .head_data(head_data)
  );

  assign m_valid    = in_run && (occ != 2'd0);
  assign m_data     = head_data;
  assign flush_busy = !in_run;
  assign deliv_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: behavioural FIFO with one-cycle read latency,
// downstream acceptance log, and one task per scenario.
module tb_fifo_rd_drain;

  localparam int DW = 4;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rst_in_rd = 1'b1;
  logic          empty_in;
  logic [DW-1:0] data_in = '0;
  logic          rd_en_out;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          flush_busy;
  logic [CW-1:0] deliv_cnt;

  int tests = 0;
  int fails = 0;

  logic          hold = 1'b1;
  logic          mdl_clr = 1'b1;
  logic          push_vld = 1'b0;
  logic [DW-1:0] push_dat = '0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] acc_q[$];
  int            acc_cyc[$];
  int            fq_n = 0;
  int            pops = 0;
  int            pop_empty = 0;
  int            cyc = 0;
  int            first_rd = -1;

  always #5 rd_clk = ~rd_clk;

  assign empty_in = hold || (fq_n == 0);

  fifo_rd_drain #(
    .data_width(DW),
    .cnt_width (CW)
  ) dut (
    .rd_clk    (rd_clk),
    .rst_in_rd (rst_in_rd),
    .empty_in  (empty_in),
    .data_in   (data_in),
    .rd_en_out (rd_en_out),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .flush     (flush),
    .flush_busy(flush_busy),
    .deliv_cnt (deliv_cnt)
  );

  // FIFO model, pop counter and downstream acceptance log
  always @(posedge rd_clk) begin
    if (mdl_clr) begin
      fq.delete();
      acc_q.delete();
      acc_cyc.delete();
      pops = 0;
      pop_empty = 0;
      cyc = 0;
      first_rd = -1;
      fq_n <= 0;
    end else begin
      if (rd_en_out) begin
        if (empty_in) pop_empty++;
        else data_in <= fq.pop_front();
        if (first_rd < 0) first_rd = cyc;
        pops++;
      end
      if (!rst_in_rd && m_valid && m_ready) begin
        acc_q.push_back(m_data);
        acc_cyc.push_back(cyc);
      end
      if (push_vld) fq.push_back(push_dat);
      fq_n <= fq.size();
      cyc++;
    end
  end

  task automatic apply_reset();
    @(negedge rd_clk);
    rst_in_rd = 1'b1;
    hold      = 1'b1;
    m_ready   = 1'b0;
    flush     = 1'b0;
    push_vld  = 1'b0;
    mdl_clr   = 1'b1;
    @(negedge rd_clk);
    @(negedge rd_clk);
    mdl_clr   = 1'b0;
    rst_in_rd = 1'b0;
  endtask

  task automatic push_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge rd_clk);
      push_vld = 1'b1;
      push_dat = DW'(base + i);
    end
    @(negedge rd_clk);
    push_vld = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic test_reset();
    apply_reset();
    push_words(8, 1);
    m_ready = 1'b1;
    hold    = 1'b0;
    wait_cyc(4);
    m_ready = 1'b0;
    wait_cyc(3);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 4'h3 || deliv_cnt !== 4'd2 || pops != 4) begin
      fails++;
      $display("FAIL reset_pre: valid=%b data=%h cnt=%0d pops=%0d exp 1/3/2/4", m_valid, m_data, deliv_cnt, pops);
    end
    rst_in_rd = 1'b1;
    #1;
    tests++;
    if (rd_en_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_rd_en: got %b exp 0", rd_en_out);
    end
    tests++;
    if (m_valid !== 1'b0 || m_data !== 4'h0) begin
      fails++;
      $display("FAIL reset_out: valid=%b data=%h exp 0/0", m_valid, m_data);
    end
    tests++;
    if (flush_busy !== 1'b0 || deliv_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b cnt=%0d exp 0/0", flush_busy, deliv_cnt);
    end
    hold = 1'b1;
    @(negedge rd_clk);
    rst_in_rd = 1'b0;
    wait_cyc(2);
    tests++;
    if (rd_en_out !== 1'b0 || m_valid !== 1'b0 || pop_empty != 0) begin
      fails++;
      $display("FAIL reset_empty_guard: rd_en=%b valid=%b pop_empty=%0d exp 0/0/0", rd_en_out, m_valid, pop_empty);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    push_words(8, 1);
    m_ready = 1'b1;
    hold    = 1'b0;
    wait_cyc(14);
    tests++;
    if (pops != 8 || pop_empty != 0 || acc_q.size() != 8) begin
      fails++;
      $display("FAIL stream_counts: pops=%0d pop_empty=%0d acc=%0d exp 8/0/8", pops, pop_empty, acc_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= acc_q.size()) begin
        fails++;
        $display("FAIL stream_word%0d: missing exp %h", i, i + 1);
      end else if (acc_q[i] !== DW'(i + 1) || acc_cyc[i] != first_rd + 2 + i) begin
        fails++;
        $display("FAIL stream_word%0d: data=%h cyc=%0d exp %h at %0d", i, acc_q[i], acc_cyc[i], i + 1, first_rd + 2 + i);
      end
    end
    tests++;
    if (deliv_cnt !== 4'd8) begin
      fails++;
      $display("FAIL stream_cnt: got %0d exp 8", deliv_cnt);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    push_words(6, 9);
    m_ready = 1'b0;
    hold    = 1'b0;
    wait_cyc(10);
    tests++;
    if (pops != 2 || m_valid !== 1'b1 || m_data !== 4'h9 || deliv_cnt !== 4'd0) begin
      fails++;
      $display("FAIL bp_stall: pops=%0d valid=%b data=%h cnt=%0d exp 2/1/9/0", pops, m_valid, m_data, deliv_cnt);
    end
    m_ready = 1'b1;
    wait_cyc(12);
    tests++;
    if (pops != 6 || acc_q.size() != 6 || deliv_cnt !== 4'd6) begin
      fails++;
      $display("FAIL bp_drain: pops=%0d acc=%0d cnt=%0d exp 6/6/6", pops, acc_q.size(), deliv_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= acc_q.size() || acc_q[i] !== DW'(9 + i)) begin
        fails++;
        $display("FAIL bp_word%0d: got %h exp %h", i, (i < acc_q.size()) ? acc_q[i] : 4'hx, DW'(9 + i));
      end
    end
  endtask

  task automatic test_empty_guard();
    apply_reset();
    push_words(1, 5);
    m_ready = 1'b1;
    hold    = 1'b0;
    wait_cyc(8);
    tests++;
    if (pops != 1 || pop_empty != 0 || rd_en_out !== 1'b0) begin
      fails++;
      $display("FAIL empty_guard_pops: pops=%0d pop_empty=%0d rd_en=%b exp 1/0/0", pops, pop_empty, rd_en_out);
    end
    tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 4'h5 || deliv_cnt !== 4'd1) begin
      fails++;
      $display("FAIL empty_guard_data: acc=%0d cnt=%0d exp 1 word 5, cnt 1", acc_q.size(), deliv_cnt);
    end
  endtask

  task automatic test_flush();
    int bad;
    int k;
    apply_reset();
    push_words(7, 1);
    m_ready = 1'b0;
    hold    = 1'b0;
    wait_cyc(5);
    tests++;
    if (m_valid !== 1'b1 || pops != 2 || fq_n != 5) begin
      fails++;
      $display("FAIL flush_pre: valid=%b pops=%0d fifo=%0d exp 1/2/5", m_valid, pops, fq_n);
    end
    flush = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      if (m_valid !== 1'b0 || flush_busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL flush_window: %0d bad cycles exp 0", bad);
    end
    tests++;
    if (pops != 7 || fq_n != 0 || pop_empty != 0) begin
      fails++;
      $display("FAIL flush_pops: pops=%0d fifo=%0d pop_empty=%0d exp 7/0/0", pops, fq_n, pop_empty);
    end
    flush = 1'b0;
    m_ready = 1'b1;
    k = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge rd_clk);
      if (flush_busy === 1'b0 && k == 0) k = i;
    end
    tests++;
    if (k < 1 || k > 2) begin
      fails++;
      $display("FAIL flush_settle: busy cleared after %0d cycles exp 1..2", k);
    end
    push_words(1, 10);
    wait_cyc(6);
    tests++;
    if (acc_q.size() != 1 || acc_q[0] !== 4'hA || deliv_cnt !== 4'd1) begin
      fails++;
      $display("FAIL flush_resume: acc=%0d cnt=%0d exp single word A, cnt 1", acc_q.size(), deliv_cnt);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    push_words(17, 0);
    m_ready = 1'b1;
    hold    = 1'b0;
    wait_cyc(24);
    tests++;
    if (deliv_cnt !== 4'd1) begin
      fails++;
      $display("FAIL wrap_cnt: got %0d exp 1", deliv_cnt);
    end
    tests++;
    if (pops != 17 || acc_q.size() != 17 || acc_q[16] !== 4'h0 || acc_q[15] !== 4'hF) begin
      fails++;
      $display("FAIL wrap_data: pops=%0d acc=%0d exp 17/17 ending F,0", pops, acc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_guard();
    test_flush();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
